// File: rtl/montgomery_pkg.sv
// ============================================================================
// montgomery_pkg : shared types and constants for the Montgomery multiplier
// Revision 1.0
// ============================================================================
`default_nettype none

package montgomery_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_FINAL = 2'd2
    } state_t;

    // 2^255 - 19
    localparam logic [254:0] CURVE25519_N = {{250{1'b1}}, 5'b01101};

    // -N^-1 mod 2^K for CURVE25519_N
    localparam logic [0:0] NPRIME_K1 = 1'b1;
    localparam logic [3:0] NPRIME_K4 = 4'd11;

    function automatic int digits(input int w, input int k);
        return (w + k - 1) / k;
    endfunction

endpackage

`default_nettype wire

// File: rtl/montgomery_digit_step.sv
// ============================================================================
// montgomery_digit_step : one combinational radix-2^K Montgomery iteration
// Revision 1.0
// ============================================================================
`default_nettype none

module montgomery_digit_step
    import montgomery_pkg::*;
#(
    parameter int P_WIDTH      = 255,
    parameter int P_RADIX_BITS = 1
) (
    input  logic [P_WIDTH:0]        i_m,
    input  logic [P_RADIX_BITS-1:0] i_a_digit,
    input  logic [P_WIDTH-1:0]      i_b,
    input  logic [P_WIDTH-1:0]      i_n,
    input  logic [P_RADIX_BITS-1:0] i_n_prime,
    output logic [P_WIDTH:0]        o_m_next
);

    localparam int c_tw = P_WIDTH + P_RADIX_BITS + 1;

    logic [c_tw-1:0]         w_m_ext;
    logic [c_tw-1:0]         w_a_ext;
    logic [c_tw-1:0]         w_b_ext;
    logic [c_tw-1:0]         w_n_ext;
    logic [c_tw-1:0]         w_q_ext;
    logic [c_tw-1:0]         w_t;
    logic [c_tw-1:0]         w_u;
    logic [P_RADIX_BITS-1:0] w_q;
    logic                    w_unused_low;

    assign w_m_ext = {{P_RADIX_BITS{1'b0}}, i_m};
    assign w_a_ext = {{(P_WIDTH + 1){1'b0}}, i_a_digit};
    assign w_b_ext = {{(P_RADIX_BITS + 1){1'b0}}, i_b};
    assign w_n_ext = {{(P_RADIX_BITS + 1){1'b0}}, i_n};

    assign w_t     = w_m_ext + w_a_ext * w_b_ext;
    // Product is evaluated in K-bit context, so the mod 2^K is implicit
    assign w_q     = w_t[P_RADIX_BITS-1:0] * i_n_prime;
    assign w_q_ext = {{(P_WIDTH + 1){1'b0}}, w_q};
    assign w_u     = w_t + w_q_ext * w_n_ext;

    // Low K bits of w_u are zero by choice of q, so the shift is exact
    assign o_m_next     = w_u[c_tw-1:P_RADIX_BITS];
    assign w_unused_low = |w_u[P_RADIX_BITS-1:0];

endmodule

`default_nettype wire

// File: rtl/montgomery_radix.sv
// ============================================================================
// montgomery_radix : radix-2^K Montgomery multiplier, result = a*b*R^-1 mod N
// Revision 1.0
// ============================================================================
`default_nettype none

module montgomery_radix
    import montgomery_pkg::*;
#(
    parameter int P_WIDTH      = 255,
    parameter int P_RADIX_BITS = 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    input  logic [P_WIDTH-1:0]      i_a,
    input  logic [P_WIDTH-1:0]      i_b,
    input  logic [P_WIDTH-1:0]      i_n,
    input  logic [P_RADIX_BITS-1:0] i_n_prime,
    output logic [P_WIDTH-1:0]      o_result,
    output logic                    o_valid,
    output logic                    o_busy
);

    localparam int                 c_digits = digits(P_WIDTH, P_RADIX_BITS);
    localparam int                 c_aw     = c_digits * P_RADIX_BITS;
    localparam int                 c_cnt_w  = $clog2(c_digits + 1);
    localparam logic [c_cnt_w-1:0] c_last   = c_cnt_w'(c_digits - 1);

    state_t                  state_q, state_d;
    logic [c_aw-1:0]         a_q, a_d;
    logic [P_WIDTH-1:0]      b_q, b_d;
    logic [P_WIDTH-1:0]      n_q, n_d;
    logic [P_RADIX_BITS-1:0] np_q, np_d;
    logic [P_WIDTH:0]        m_q, m_d;
    logic [c_cnt_w-1:0]      cnt_q, cnt_d;
    logic [P_WIDTH-1:0]      result_q, result_d;
    logic                    valid_q, valid_d;

    logic                    w_accept;
    logic                    w_calc;
    logic                    w_final;
    logic                    w_last;
    logic                    w_m_ge;
    logic [P_WIDTH:0]        w_m_next;
    logic [P_WIDTH:0]        w_m_sub;
    logic                    w_unused_sub_msb;

    montgomery_digit_step #(
        .P_WIDTH      (P_WIDTH),
        .P_RADIX_BITS (P_RADIX_BITS)
    ) u_step (
        .i_m       (m_q),
        .i_a_digit (a_q[P_RADIX_BITS-1:0]),
        .i_b       (b_q),
        .i_n       (n_q),
        .i_n_prime (np_q),
        .o_m_next  (w_m_next)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (i_start) state_d = S_CALC;
            S_CALC:  if (w_last)  state_d = S_FINAL;
            S_FINAL: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        w_accept = (state_q == S_IDLE) && i_start;
        w_calc   = (state_q == S_CALC);
        w_final  = (state_q == S_FINAL);
        o_busy   = (state_q != S_IDLE);
    end

    assign w_last           = (cnt_q == c_last);
    assign w_m_ge           = (m_q >= {1'b0, n_q});
    assign w_m_sub          = m_q - {1'b0, n_q};
    // m < 2N, so after one conditional subtract the MSB is always clear
    assign w_unused_sub_msb = w_m_sub[P_WIDTH];

    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        n_d      = n_q;
        np_d     = np_q;
        m_d      = m_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        valid_d  = w_final;
        if (w_accept) begin
            a_d   = c_aw'(i_a);
            b_d   = i_b;
            n_d   = i_n;
            np_d  = i_n_prime;
            m_d   = '0;
            cnt_d = '0;
        end
        if (w_calc) begin
            m_d   = w_m_next;
            a_d   = a_q >> P_RADIX_BITS;
            cnt_d = cnt_q + c_cnt_w'(1);
        end
        if (w_final) begin
            result_d = w_m_ge ? w_m_sub[P_WIDTH-1:0] : m_q[P_WIDTH-1:0];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            a_q      <= '0;
            b_q      <= '0;
            n_q      <= '0;
            np_q     <= '0;
            m_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            n_q      <= n_d;
            np_q     <= np_d;
            m_q      <= m_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            valid_q  <= valid_d;
        end
    end

    assign o_result = result_q;
    assign o_valid  = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_montgomery_radix.sv
// ============================================================================
// tb_montgomery_radix : directed bench over W=8/K=2, W=255/K=1, W=255/K=4
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_montgomery_radix;
    import montgomery_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic [254:0] a, b, n;
    logic [3:0]   np;
    logic         st8, st1, st4;

    logic [7:0]   r8;
    logic         v8, by8;
    logic [254:0] r1, r4;
    logic         v1, by1, v4, by4;

    int tests = 0;
    int fails = 0;
    int lat, busy_n, nv;
    logic [254:0] nm1;

    always #5 clk = ~clk;

    montgomery_radix #(.P_WIDTH(8), .P_RADIX_BITS(2)) u8 (
        .i_clk(clk), .i_rst(rst), .i_start(st8), .i_a(a[7:0]), .i_b(b[7:0]),
        .i_n(n[7:0]), .i_n_prime(np[1:0]), .o_result(r8), .o_valid(v8), .o_busy(by8)
    );

    montgomery_radix #(.P_WIDTH(255), .P_RADIX_BITS(1)) u1 (
        .i_clk(clk), .i_rst(rst), .i_start(st1), .i_a(a), .i_b(b),
        .i_n(n), .i_n_prime(np[0:0]), .o_result(r1), .o_valid(v1), .o_busy(by1)
    );

    montgomery_radix #(.P_WIDTH(255), .P_RADIX_BITS(4)) u4 (
        .i_clk(clk), .i_rst(rst), .i_start(st4), .i_a(a), .i_b(b),
        .i_n(n), .i_n_prime(np), .o_result(r4), .o_valid(v4), .o_busy(by4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic vsel(input int s);
        case (s)
            0:       return v8;
            1:       return v1;
            default: return v4;
        endcase
    endfunction

    function automatic logic bsel(input int s);
        case (s)
            0:       return by8;
            1:       return by1;
            default: return by4;
        endcase
    endfunction

    // Start one instance, then count edges until its o_valid (bounded)
    task automatic run(input int sel, output int l, output int bn);
        case (sel)
            0:       st8 = 1'b1;
            1:       st1 = 1'b1;
            default: st4 = 1'b1;
        endcase
        tick();
        st8 = 1'b0; st1 = 1'b0; st4 = 1'b0;
        l  = 0;
        bn = 0;
        while (l < 400) begin
            if (bsel(sel)) bn++;
            tick();
            l++;
            if (vsel(sel)) break;
        end
    endtask

    initial begin
        rst = 1'b1; st8 = 1'b0; st1 = 1'b0; st4 = 1'b0;
        a = '0; b = '0; n = '0; np = '0;
        nm1 = CURVE25519_N - 255'd1;
        tick(); tick();
        rst = 1'b0;

        chk("rst_result8", r8, 0);
        chk("rst_valid_busy8", {v8, by8}, 0);
        chk("rst_result1", r1, 0);
        chk("rst_valid_busy1", {v1, by1}, 0);
        chk("rst_out4", {r4, v4, by4}, 0);

        // W=8 K=2 N=13: 5*7*256^-1 mod 13 = 1
        n = 255'd13; np = 4'd3; a = 255'd5; b = 255'd7;
        run(0, lat, busy_n);
        chk("k2_result", r8, 1);
        chk("k2_latency", lat, 5);
        chk("k2_busy_cycles", busy_n, 5);
        chk("k2_busy_in_valid", by8, 0);
        tick();
        chk("k2_valid_one_cycle", v8, 0);

        // W=255 K=1: a = R mod N, so result = b
        n = CURVE25519_N; np = {3'b0, NPRIME_K1}; a = 255'd19; b = 255'd5;
        run(1, lat, busy_n);
        chk("k1_result", r1, 5);
        chk("k1_latency", lat, 256);

        a = 255'd0; b = nm1;
        run(1, lat, busy_n);
        chk("k1_zero_a", r1, 0);

        a = 255'd19; b = nm1;
        run(1, lat, busy_n);
        chk("k1_final_sub_bound", r1, nm1);

        // W=255 K=4: a = 2^256 mod N, so result = b; mid-run start and input changes ignored
        np = NPRIME_K4; a = 255'd38; b = 255'd1234;
        st4 = 1'b1; tick(); st4 = 1'b0;
        lat = 0;
        repeat (10) begin tick(); lat++; end
        a = 255'd5; b = 255'd999; st4 = 1'b1;
        tick(); lat++;
        st4 = 1'b0; b = 255'd3; n = 255'd17;
        while (lat < 400 && !v4) begin tick(); lat++; end
        chk("k4_latency", lat, 65);
        chk("k4_result_busy_start", r4, 1234);

        n = CURVE25519_N; a = 255'd38; b = 255'd777;
        chk("k4_valid_at_b2b", v4, 1);
        run(2, lat, busy_n);
        chk("k4_b2b_latency", lat, 65);
        chk("k4_b2b_result", r4, 777);
        tick();
        chk("k4_valid_one_cycle", v4, 0);

        // Reset after iteration 30 of a K=1 run
        np = {3'b0, NPRIME_K1}; a = 255'd19; b = 255'd5;
        st1 = 1'b1; tick(); st1 = 1'b0;
        repeat (30) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rst_mid_busy", by1, 0);
        chk("rst_mid_result", r1, 0);
        chk("rst_mid_valid", v1, 0);
        nv = 0;
        repeat (300) begin tick(); if (v1) nv++; end
        chk("rst_mid_no_valid", nv, 0);

        rst = 1'b1; st1 = 1'b1; tick();
        rst = 1'b0; st1 = 1'b0;
        chk("rst_beats_start", by1, 0);
        tick();
        chk("rst_start_dropped", by1, 0);

        b = 255'd7;
        run(1, lat, busy_n);
        chk("after_rst_result", r1, 7);
        chk("after_rst_latency", lat, 256);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
